btn_cond: RTL and testbench

BTN_COND -- requirements
Module: btn_cond

---
 rtl/btn_pkg.sv | 28 ++
 rtl/btn_sync.sv | 32 +++
 rtl/btn_cond.sv | 178 +++++++++++++++++
 tb/tb_btn_cond.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encoding and
// counter widths used by btn_cond (and any other button channel built on it).
package btn_pkg;

    // Debounce counter width; DB_COUNT must fit (1..15).
    localparam int unsigned CntW = 4;

    // Auto-repeat strobe counter width; REPEAT_PERIOD must fit (1..255).
    localparam int unsigned RptW = 8;

    // Debounce FSM states.
    //   StIdle      : released and stable
    //   StArming    : press seen, qualifying
    //   StPressed   : press accepted
    //   StReleasing : release seen, qualifying
    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StArming    = 2'd1,
        StPressed   = 2'd2,
        StReleasing = 2'd3
    } btn_state_e;

    // True for the states in which the debounced level reads as pressed.
    function automatic logic state_is_down(input btn_state_e st);
        return (st == StPressed) || (st == StReleasing);
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for an asynchronous push-button level. Reset clears
// both stages so a freshly released reset never reports a stale press.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next-state: shift the raw level through the two stages.
    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    // Synchronizer stages with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/btn_cond.sv
// Push-button conditioner: synchronizes btn_raw, debounces it on slowen
// strobes and produces a debounced level plus a one-clk press pulse.
// Optional auto-repeat while held is enabled by defining BTN_AUTO_REPEAT_EN.
module btn_cond
    import btn_pkg::*;
#(
    parameter int unsigned DB_COUNT      = 4,
    parameter int unsigned REPEAT_PERIOD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic slowen,
    input  logic btn_raw,
    output logic press,
    output logic level
);

    // Reject out-of-range configurations at elaboration time.
    if (DB_COUNT < 1 || DB_COUNT > 15) begin : g_bad_db_count
        $error("btn_cond: DB_COUNT must be in 1..15");
    end
    if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > 255) begin : g_bad_repeat_period
        $error("btn_cond: REPEAT_PERIOD must be in 1..255");
    end

    localparam logic [CntW-1:0] DbLast = CntW'(DB_COUNT);
    localparam logic [CntW-1:0] CntOne = CntW'(1);
    // With a single-sample debounce the intermediate states are skipped.
    localparam bit DbSingle = (DB_COUNT == 1);

    logic btn_s;

    btn_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] cnt_inc;
    logic            accept;
    logic            rpt_fire;
    logic            press_q, press_d;
    logic            level_q, level_d;

    btn_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (btn_raw),
        .q_o (btn_s)
    );

    assign cnt_inc = cnt_q + CntOne;

    // Debounce FSM next-state; state and counter only move on slowen strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (slowen) begin
            unique case (state_q)
                StIdle: begin
                    if (btn_s) begin
                        if (DbSingle) begin
                            state_d = StPressed;
                            cnt_d   = '0;
                            accept  = 1'b1;
                        end else begin
                            state_d = StArming;
                            cnt_d   = CntOne;
                        end
                    end
                end
                StArming: begin
                    if (btn_s) begin
                        if (cnt_inc == DbLast) begin
                            state_d = StPressed;
                            cnt_d   = '0;
                            accept  = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // Bounce: discard progress silently.
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
                StPressed: begin
                    if (!btn_s) begin
                        if (DbSingle) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else begin
                            state_d = StReleasing;
                            cnt_d   = CntOne;
                        end
                    end
                end
                StReleasing: begin
                    if (!btn_s) begin
                        if (cnt_inc == DbLast) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // Release bounce: back to pressed without a new pulse.
                        state_d = StPressed;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [RptW-1:0] RptLast = RptW'(REPEAT_PERIOD);
    localparam logic [RptW-1:0] RptOne  = RptW'(1);

    logic [RptW-1:0] rpt_q, rpt_d;
    logic [RptW-1:0] rpt_inc;

    assign rpt_inc = rpt_q + RptOne;

    // Repeat counter: restart on entering PRESSED, count strobes while staying.
    always_comb begin
        rpt_d    = rpt_q;
        rpt_fire = 1'b0;
        if (state_q != StPressed && state_d == StPressed) begin
            rpt_d = '0;
        end else if (slowen && state_q == StPressed && state_d == StPressed) begin
            if (rpt_inc == RptLast) begin
                rpt_d    = '0;
                rpt_fire = 1'b1;
            end else begin
                rpt_d = rpt_inc;
            end
        end
    end

    // Repeat counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Output next-state: level tracks the next FSM state so both change together.
    always_comb begin
        press_d = accept | rpt_fire;
        level_d = state_is_down(state_d);
    end

    // FSM, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            press_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            level_q <= level_d;
        end
    end

    assign press = press_q;
    assign level = level_q;

endmodule

// File: tb/tb_btn_cond.sv
// Directed bench for btn_cond: DB_COUNT=4 with slowen every 4 clk, plus a
// DB_COUNT=1 instance with slowen tied high.
module tb_btn_cond;

    logic clk;
    logic rst;
    logic slowen;
    logic btn_raw;
    logic press;
    logic level;
    logic btn_raw1;
    logic press1;
    logic level1;

    int checks;
    int errors;
    int div;
    int press_cnt;
    int press1_cnt;
    int wide_cnt;
    logic press_prev;
    logic press1_prev;

`ifdef BTN_AUTO_REPEAT_EN
    localparam int ExpRepeats = 5;
`else
    localparam int ExpRepeats = 0;
`endif

    btn_cond #(
        .DB_COUNT      (4),
        .REPEAT_PERIOD (8)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .slowen  (slowen),
        .btn_raw (btn_raw),
        .press   (press),
        .level   (level)
    );

    btn_cond #(
        .DB_COUNT      (1),
        .REPEAT_PERIOD (255)
    ) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .slowen  (1'b1),
        .btn_raw (btn_raw1),
        .press   (press1),
        .level   (level1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock: sample outputs at the falling edge, then drive the next strobe.
    task automatic tick();
        @(negedge clk);
        if (press === 1'b1) press_cnt++;
        if (press === 1'b1 && press_prev === 1'b1) wide_cnt++;
        press_prev = press;
        if (press1 === 1'b1) press1_cnt++;
        if (press1 === 1'b1 && press1_prev === 1'b1) wide_cnt++;
        press1_prev = press1;
        div = (div == 3) ? 0 : div + 1;
        slowen = (div == 0);
    endtask

    // Returns with a strobe scheduled for the next rising edge.
    task automatic align();
        tick();
        while (slowen !== 1'b1) tick();
    endtask

    // Bounded wait for a press pulse; lat = -1 when the budget runs out.
    task automatic wait_press(input int max_ticks, output int lat, output logic lvl_before);
        lat = -1;
        lvl_before = 1'bx;
        for (int i = 1; i <= max_ticks; i++) begin
            lvl_before = level;
            tick();
            if (press === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (press !== 1'b0 || level !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: press=%b level=%b, want 0 0", press, level);
        end
        tick();
        tick();
        checks++;
        if (press1 !== 1'b0 || level1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_db1: press1=%b level1=%b, want 0 0", press1, level1);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (press !== 1'b0 || level !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: press=%b level=%b, want 0 0", press, level);
        end
    endtask

    task automatic test_press();
        int lat;
        logic lb;
        int c0;
        align();
        btn_raw = 1'b1;
        c0 = press_cnt;
        wait_press(40, lat, lb);
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("FAIL press_latency: got %0d clk, want 17", lat);
        end
        checks++;
        if (level !== 1'b1 || lb !== 1'b0) begin
            errors++;
            $display("FAIL press_level: level=%b before=%b, want 1 0", level, lb);
        end
        checks++;
        if (press_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL press_count: got %0d, want 1", press_cnt - c0);
        end
    endtask

    task automatic test_hold();
        int c0;
`ifdef BTN_AUTO_REPEAT_EN
        int last;
        int gap_bad;
        last = 0;
        gap_bad = 0;
`endif
        c0 = press_cnt;
        for (int i = 1; i <= 160; i++) begin
            tick();
`ifdef BTN_AUTO_REPEAT_EN
            if (press === 1'b1) begin
                if (i - last != 32) gap_bad++;
                last = i;
            end
`endif
        end
        checks++;
        if (press_cnt - c0 !== ExpRepeats) begin
            errors++;
            $display("FAIL hold_repeats: got %0d, want %0d", press_cnt - c0, ExpRepeats);
        end
`ifdef BTN_AUTO_REPEAT_EN
        checks++;
        if (gap_bad !== 0 || last !== 160) begin
            errors++;
            $display("FAIL hold_spacing: bad gaps %0d last %0d, want 0 160", gap_bad, last);
        end
`endif
        checks++;
        if (level !== 1'b1) begin
            errors++;
            $display("FAIL hold_level: got %b, want 1", level);
        end
    endtask

    task automatic test_release_glitch();
        int c0;
        int low_seen;
        logic l16;
        align();
        btn_raw = 1'b0;
        c0 = press_cnt;
        low_seen = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 10) btn_raw = 1'b1;
            if (level !== 1'b1) low_seen++;
        end
        checks++;
        if (low_seen !== 0) begin
            errors++;
            $display("FAIL glitch_level: level low for %0d clk, want 0", low_seen);
        end
        checks++;
        if (press_cnt - c0 !== 0) begin
            errors++;
            $display("FAIL glitch_press: got %0d pulses, want 0", press_cnt - c0);
        end
        align();
        btn_raw = 1'b0;
        for (int i = 1; i <= 16; i++) tick();
        l16 = level;
        tick();
        checks++;
        if (l16 !== 1'b1 || level !== 1'b0) begin
            errors++;
            $display("FAIL release_level: clk16=%b clk17=%b, want 1 0", l16, level);
        end
    endtask

    task automatic test_bounce();
        int c0;
        int high_seen;
        int lat;
        logic lb;
        align();
        btn_raw = 1'b1;
        c0 = press_cnt;
        high_seen = 0;
        for (int i = 1; i <= 34; i++) begin
            tick();
            if (i == 14) btn_raw = 1'b0;
            if (level !== 1'b0) high_seen++;
        end
        checks++;
        if (press_cnt - c0 !== 0 || high_seen !== 0) begin
            errors++;
            $display("FAIL bounce: pulses %0d level-high %0d, want 0 0", press_cnt - c0,
                     high_seen);
        end
        align();
        btn_raw = 1'b1;
        wait_press(40, lat, lb);
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("FAIL bounce_requalify: got %0d clk, want 17", lat);
        end
        btn_raw = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        checks++;
        if (level !== 1'b0) begin
            errors++;
            $display("FAIL bounce_release: level=%b, want 0", level);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        int lat;
        logic lb;
        align();
        btn_raw = 1'b1;
        c0 = press_cnt;
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (press_cnt - c0 !== 0 || level !== 1'b0) begin
            errors++;
            $display("FAIL arming_quiet: pulses %0d level %b, want 0 0", press_cnt - c0, level);
        end
        rst = 1'b1;
        align();
        rst = 1'b0;
        wait_press(40, lat, lb);
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("FAIL reset_arming_latency: got %0d clk, want 17", lat);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (level !== 1'b0 || press !== 1'b0) begin
            errors++;
            $display("FAIL reset_pressed_async: level=%b press=%b, want 0 0", level, press);
        end
        align();
        rst = 1'b0;
        wait_press(40, lat, lb);
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("FAIL reset_pressed_latency: got %0d clk, want 17", lat);
        end
        btn_raw = 1'b0;
        for (int i = 0; i < 40; i++) tick();
    endtask

    task automatic test_db_one();
        int c1;
        logic [4:1] p;
        logic [4:1] l;
        logic l2;
        tick();
        btn_raw1 = 1'b1;
        c1 = press1_cnt;
        for (int i = 1; i <= 4; i++) begin
            tick();
            p[i] = press1;
            l[i] = level1;
        end
        checks++;
        if (p !== 4'b0100) begin
            errors++;
            $display("FAIL db1_press_timing: clk4..1=%b, want 0100", p);
        end
        checks++;
        if (l !== 4'b1100) begin
            errors++;
            $display("FAIL db1_level_timing: clk4..1=%b, want 1100", l);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (press1_cnt - c1 !== 1 || level1 !== 1'b1) begin
            errors++;
            $display("FAIL db1_held: pulses %0d level %b, want 1 1", press1_cnt - c1, level1);
        end
        btn_raw1 = 1'b0;
        tick();
        tick();
        l2 = level1;
        tick();
        checks++;
        if (l2 !== 1'b1 || level1 !== 1'b0) begin
            errors++;
            $display("FAIL db1_release: clk2=%b clk3=%b, want 1 0", l2, level1);
        end
    endtask

    task automatic test_pulse_width();
        checks++;
        if (wide_cnt !== 0) begin
            errors++;
            $display("FAIL pulse_width: %0d multi-clk pulses, want 0", wide_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        div = 0;
        press_cnt = 0;
        press1_cnt = 0;
        wide_cnt = 0;
        press_prev = 1'b0;
        press1_prev = 1'b0;
        rst = 1'b1;
        slowen = 1'b0;
        btn_raw = 1'b0;
        btn_raw1 = 1'b0;
        test_reset();
        test_press();
        test_hold();
        test_release_glitch();
        test_bounce();
        test_reset_mid();
        test_db_one();
        test_pulse_width();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
